// File: rtl/meas_readout.sv
// rtl/meas_readout.sv - per-channel sample-memory reader with strobe/ack MCU handshake
// Builds the SRAM address from a channel base plus running offset and returns one byte per request.
module meas_readout #(
  parameter int CH_NUM      = 25,
  parameter int MEM_WAIT    = 2,
  parameter int SMALL_DEPTH = 4096,
  parameter int LARGE_DEPTH = 65536
) (
  input  logic        clk,
  input  logic        mcu_rst,
  input  logic        mcu_end,
  input  logic [4:0]  rd_ch_sel,
  input  logic        rd_load,
  input  logic        rd_req,
  output logic [19:0] mem_addr,
  output logic        mem_oe,
  input  logic [7:0]  mem_data,
  output logic [7:0]  rd_data,
  output logic        rd_ack,
  output logic        rd_last,
  output logic        rd_err
);

  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

  localparam logic [4:0] CH_MAX    = 5'(CH_NUM);
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t      state, state_next;
  logic        req_s1, req_s2, req_prev;
  logic        req_rise;
  logic [4:0]  ch;
  logic [15:0] offset;
  logic [3:0]  wait_cnt;
  logic [19:0] base;
  logic [15:0] last_off;
  logic        wait_last;
  logic        sel_valid;
  logic        load_ok, err_set, latch_byte, advance;

  assign req_rise  = req_s2 & ~req_prev;
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign sel_valid = (rd_ch_sel >= 5'd1) && (rd_ch_sel <= CH_MAX);

  // Channel map shared with the capture path: three banks, the middle one 64 KiB per channel.
  always_comb begin
    base     = '0;
    last_off = 16'(SMALL_DEPTH - 1);
    if (ch >= 5'd1 && ch <= 5'd9) begin
      base = 20'(ch - 5'd1) << 12;
    end else if (ch >= 5'd10 && ch <= 5'd13) begin
      base     = 20'h09000 + (20'(ch - 5'd10) << 16);
      last_off = 16'(LARGE_DEPTH - 1);
    end else if (ch >= 5'd14) begin
      base = 20'h49000 + (20'(ch - 5'd14) << 12);
    end
  end

  assign mem_addr = (ch == 5'd0) ? 20'h7FFF0 : base + {4'b0000, offset};
  assign mem_oe   = (state == READ);
  assign rd_ack   = (state == ACK);

  always_ff @(posedge clk) begin
    if (mcu_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ok    = 1'b0;
    err_set    = 1'b0;
    latch_byte = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_load) begin
          if (sel_valid) load_ok = 1'b1;
          else           err_set = 1'b1;
        end
        if (req_rise) begin
          if (mcu_end && ch != 5'd0) state_next = READ;
          else                       err_set    = 1'b1;
        end
      end
      READ: begin
        if (rd_load) err_set = 1'b1;
        if (wait_last) begin
          latch_byte = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (rd_load) err_set = 1'b1;
        if (!req_s2) begin
          advance    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mcu_rst) begin
      req_s1   <= 1'b0;
      req_s2   <= 1'b0;
      req_prev <= 1'b0;
      ch       <= 5'd0;
      offset   <= 16'd0;
      wait_cnt <= 4'd0;
      rd_data  <= 8'h00;
      rd_last  <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      req_s1   <= rd_req;
      req_s2   <= req_s1;
      req_prev <= req_s2;
      wait_cnt <= (state == READ && !wait_last) ? wait_cnt + 4'd1 : 4'd0;
      if (load_ok) begin
        ch      <= rd_ch_sel;
        offset  <= 16'd0;
        rd_last <= 1'b0;
        rd_err  <= 1'b0;
      end
      // A failed request in the same cycle as a good load still leaves the flag set.
      if (err_set) rd_err <= 1'b1;
      if (latch_byte) begin
        rd_data <= mem_data;
        rd_last <= (offset == last_off);
      end
      if (advance) offset <= (offset == last_off) ? 16'd0 : offset + 16'd1;
    end
  end

endmodule

// File: tb/tb_meas_readout.sv
// tb/tb_meas_readout.sv - directed bench for meas_readout
module tb_meas_readout;
  localparam int MEM_WAIT = 2;

  logic        clk = 1'b0;
  logic        mcu_rst, mcu_end, rd_load, rd_req;
  logic [4:0]  rd_ch_sel;
  logic [19:0] mem_addr;
  logic        mem_oe;
  logic [7:0]  mem_data;
  logic [7:0]  rd_data;
  logic        rd_ack, rd_last, rd_err;
  int          oe_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  meas_readout #(.CH_NUM(25), .MEM_WAIT(MEM_WAIT), .SMALL_DEPTH(4096), .LARGE_DEPTH(65536)) dut (
    .clk(clk), .mcu_rst(mcu_rst), .mcu_end(mcu_end), .rd_ch_sel(rd_ch_sel), .rd_load(rd_load),
    .rd_req(rd_req), .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_data(mem_data),
    .rd_data(rd_data), .rd_ack(rd_ack), .rd_last(rd_last), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[3:0]} ^ 8'hA5;
  endfunction

  // SRAM model: data only settles after MEM_WAIT cycles of output enable.
  always @(posedge clk) oe_cnt <= mem_oe ? oe_cnt + 1 : 0;
  assign mem_data = (mem_oe && oe_cnt >= MEM_WAIT - 1) ? mem_model(mem_addr) : 8'hEE;

  task automatic apply_reset();
    @(negedge clk);
    mcu_rst = 1'b1; rd_req = 1'b0; rd_load = 1'b0;
    repeat (2) @(negedge clk);
    mcu_rst = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] sel);
    @(negedge clk);
    rd_load = 1'b1; rd_ch_sel = sel;
    @(negedge clk);
    rd_load = 1'b0;
  endtask

  task automatic do_read(output logic [7:0] d, output logic l, output int oe_n,
                         output logic [19:0] a, output logic ok);
    int n;
    ok = 1'b1; oe_n = 0; a = 20'h0;
    @(negedge clk);
    rd_req = 1'b1;
    n = 0;
    while (rd_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      if (mem_oe === 1'b1) begin oe_n++; a = mem_addr; end
      n++;
    end
    if (rd_ack !== 1'b1) ok = 1'b0;
    d = rd_data; l = rd_last;
    rd_req = 1'b0;
    n = 0;
    while (rd_ack !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    if (rd_ack !== 1'b0) ok = 1'b0;
  endtask

  task automatic pulse_req(output int oe_n, output int ack_n);
    oe_n = 0; ack_n = 0;
    @(negedge clk);
    rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 6) rd_req = 1'b0;
      if (mem_oe === 1'b1) oe_n++;
      if (rd_ack === 1'b1) ack_n++;
    end
  endtask

  task automatic test_reset();
    mcu_end = 1'b1; rd_ch_sel = 5'd0;
    apply_reset();
    @(negedge clk);
    n_cmp++; if (mem_addr !== 20'h7FFF0) begin n_bad++; $display("FAIL rst_addr got %h exp 7fff0", mem_addr); end
    n_cmp++; if ({mem_oe, rd_ack, rd_last, rd_err} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b exp 0000", {mem_oe, rd_ack, rd_last, rd_err}); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h exp 00", rd_data); end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic l, ok; int oe_n; logic [19:0] a;
    do_load(5'd3);
    n_cmp++; if (mem_addr !== 20'h02000) begin n_bad++; $display("FAIL ch3_load_addr got %h exp 02000", mem_addr); end
    do_read(d, l, oe_n, a, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ch3_handshake got %b exp 1", ok); end
    n_cmp++; if (oe_n !== MEM_WAIT) begin n_bad++; $display("FAIL ch3_oe_cycles got %0d exp %0d", oe_n, MEM_WAIT); end
    n_cmp++; if (a !== 20'h02000) begin n_bad++; $display("FAIL ch3_read_addr got %h exp 02000", a); end
    n_cmp++; if (d !== mem_model(20'h02000)) begin n_bad++; $display("FAIL ch3_data got %h exp %h", d, mem_model(20'h02000)); end
    n_cmp++; if (l !== 1'b0) begin n_bad++; $display("FAIL ch3_last got %b exp 0", l); end
    n_cmp++; if (mem_addr !== 20'h02001) begin n_bad++; $display("FAIL ch3_next_addr got %h exp 02001", mem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic l, ok; int oe_n; logic [19:0] a;
    for (int i = 1; i <= 3; i++) begin
      do_read(d, l, oe_n, a, ok);
      n_cmp++; if (ok !== 1'b1 || a !== 20'h02000 + 20'(i)) begin n_bad++; $display("FAIL b2b_addr[%0d] got %h ok %b exp %h", i, a, ok, 20'h02000 + 20'(i)); end
      n_cmp++; if (d !== mem_model(20'h02000 + 20'(i))) begin n_bad++; $display("FAIL b2b_data[%0d] got %h exp %h", i, d, mem_model(20'h02000 + 20'(i))); end
    end
  endtask

  task automatic test_large_wrap();
    logic [7:0] d; logic l, ok; int oe_n; logic [19:0] a;
    do_load(5'd10);
    n_cmp++; if (mem_addr !== 20'h09000) begin n_bad++; $display("FAIL ch10_base got %h exp 09000", mem_addr); end
    @(negedge clk);
    force dut.offset = 16'hFFFF;
    @(negedge clk);
    release dut.offset;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 20'h18FFF) begin n_bad++; $display("FAIL ch10_top_addr got %h exp 18fff", mem_addr); end
    do_read(d, l, oe_n, a, ok);
    n_cmp++; if (ok !== 1'b1 || a !== 20'h18FFF) begin n_bad++; $display("FAIL ch10_read_addr got %h ok %b exp 18fff", a, ok); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL ch10_last got %b exp 1", l); end
    n_cmp++; if (d !== mem_model(20'h18FFF)) begin n_bad++; $display("FAIL ch10_data got %h exp %h", d, mem_model(20'h18FFF)); end
    n_cmp++; if (mem_addr !== 20'h09000) begin n_bad++; $display("FAIL ch10_wrap_addr got %h exp 09000", mem_addr); end
    do_read(d, l, oe_n, a, ok);
    n_cmp++; if (l !== 1'b0 || a !== 20'h09000) begin n_bad++; $display("FAIL ch10_after_wrap got last %b addr %h exp 0 09000", l, a); end
  endtask

  task automatic test_ch25_sweep();
    logic [7:0] d; logic l, ok; int oe_n; logic [19:0] a, exp_a;
    int bad_a, bad_d, bad_l, bad_ok;
    bad_a = 0; bad_d = 0; bad_l = 0; bad_ok = 0;
    do_load(5'd25);
    n_cmp++; if (mem_addr !== 20'h54000 || rd_last !== 1'b0) begin n_bad++; $display("FAIL ch25_load got %h last %b exp 54000 0", mem_addr, rd_last); end
    for (int i = 0; i < 4096; i++) begin
      exp_a = 20'h54000 + 20'(i);
      do_read(d, l, oe_n, a, ok);
      if (a !== exp_a) bad_a++;
      if (d !== mem_model(exp_a)) bad_d++;
      if (l !== (i == 4095)) bad_l++;
      if (ok !== 1'b1 || oe_n !== MEM_WAIT) bad_ok++;
    end
    n_cmp++; if (bad_a !== 0) begin n_bad++; $display("FAIL ch25_addr_run got %0d bad exp 0", bad_a); end
    n_cmp++; if (bad_d !== 0) begin n_bad++; $display("FAIL ch25_data_run got %0d bad exp 0", bad_d); end
    n_cmp++; if (bad_l !== 0) begin n_bad++; $display("FAIL ch25_last_run got %0d bad exp 0", bad_l); end
    n_cmp++; if (bad_ok !== 0) begin n_bad++; $display("FAIL ch25_handshake_run got %0d bad exp 0", bad_ok); end
    n_cmp++; if (mem_addr !== 20'h54000) begin n_bad++; $display("FAIL ch25_wrap got %h exp 54000", mem_addr); end
  endtask

  task automatic test_err_no_end();
    int oe_n, ack_n;
    do_load(5'd3);
    mcu_end = 1'b0;
    pulse_req(oe_n, ack_n);
    n_cmp++; if (oe_n !== 0 || ack_n !== 0) begin n_bad++; $display("FAIL noend_activity got oe %0d ack %0d exp 0 0", oe_n, ack_n); end
    n_cmp++; if (rd_err !== 1'b1) begin n_bad++; $display("FAIL noend_err got %b exp 1", rd_err); end
    mcu_end = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_bad++; $display("FAIL noend_err_sticky got %b exp 1", rd_err); end
    do_load(5'd3);
    n_cmp++; if (rd_err !== 1'b0) begin n_bad++; $display("FAIL noend_err_clear got %b exp 0", rd_err); end
  endtask

  task automatic test_bad_load();
    int n;
    do_load(5'd3);
    do_load(5'd0);
    n_cmp++; if (rd_err !== 1'b1 || mem_addr !== 20'h02000) begin n_bad++; $display("FAIL load0 got err %b addr %h exp 1 02000", rd_err, mem_addr); end
    do_load(5'd3);
    do_load(5'd26);
    n_cmp++; if (rd_err !== 1'b1 || mem_addr !== 20'h02000) begin n_bad++; $display("FAIL load26 got err %b addr %h exp 1 02000", rd_err, mem_addr); end
    do_load(5'd3);
    @(negedge clk);
    rd_req = 1'b1;
    n = 0;
    while (mem_oe !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    rd_load = 1'b1; rd_ch_sel = 5'd5;
    @(negedge clk);
    rd_load = 1'b0;
    n = 0;
    while (rd_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (rd_ack !== 1'b1 || rd_err !== 1'b1 || mem_addr !== 20'h02000) begin n_bad++; $display("FAIL load_in_read got ack %b err %b addr %h exp 1 1 02000", rd_ack, rd_err, mem_addr); end
    rd_req = 1'b0;
    n = 0;
    while (rd_ack !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (mem_addr !== 20'h02001) begin n_bad++; $display("FAIL load_in_read_after got %h exp 02001", mem_addr); end
  endtask

  task automatic test_rst_in_read();
    logic [7:0] d; logic l, ok; int oe_n, n; logic [19:0] a;
    do_load(5'd3);
    do_read(d, l, oe_n, a, ok);
    @(negedge clk);
    rd_req = 1'b1;
    n = 0;
    while (mem_oe !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (mem_oe !== 1'b1 || rd_data === 8'h00) begin n_bad++; $display("FAIL rstread_setup got oe %b data %h exp 1 nonzero", mem_oe, rd_data); end
    mcu_rst = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    mcu_rst = 1'b0;
    n_cmp++; if ({mem_oe, rd_ack} !== 2'b00 || mem_addr !== 20'h7FFF0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_in_read got oe %b ack %b addr %h data %h exp 0 0 7fff0 00", mem_oe, rd_ack, mem_addr, rd_data); end
    @(negedge clk);
    n_cmp++; if ({mem_oe, rd_ack, rd_err} !== 3'b000) begin n_bad++; $display("FAIL rst_in_read_idle got %b exp 000", {mem_oe, rd_ack, rd_err}); end
  endtask

  task automatic test_rst_in_ack();
    logic [7:0] d; logic l, ok; int oe_n, n; logic [19:0] a;
    do_load(5'd3);
    do_read(d, l, oe_n, a, ok);
    @(negedge clk);
    rd_req = 1'b1;
    n = 0;
    while (rd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (rd_ack !== 1'b1 || rd_data !== mem_model(20'h02001)) begin n_bad++; $display("FAIL rstack_setup got ack %b data %h exp 1 %h", rd_ack, rd_data, mem_model(20'h02001)); end
    mcu_rst = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    mcu_rst = 1'b0;
    n_cmp++; if ({mem_oe, rd_ack} !== 2'b00 || mem_addr !== 20'h7FFF0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_in_ack got oe %b ack %b addr %h data %h exp 0 0 7fff0 00", mem_oe, rd_ack, mem_addr, rd_data); end
    @(negedge clk);
    n_cmp++; if ({mem_oe, rd_ack, rd_last} !== 3'b000) begin n_bad++; $display("FAIL rst_in_ack_idle got %b exp 000", {mem_oe, rd_ack, rd_last}); end
  endtask

  task automatic test_err_no_channel();
    int oe_n, ack_n;
    mcu_end = 1'b1;
    pulse_req(oe_n, ack_n);
    n_cmp++; if (oe_n !== 0 || ack_n !== 0) begin n_bad++; $display("FAIL nochan_activity got oe %0d ack %0d exp 0 0", oe_n, ack_n); end
    n_cmp++; if (rd_err !== 1'b1 || mem_addr !== 20'h7FFF0) begin n_bad++; $display("FAIL nochan_err got err %b addr %h exp 1 7fff0", rd_err, mem_addr); end
    do_load(5'd14);
    n_cmp++; if (rd_err !== 1'b0 || mem_addr !== 20'h49000) begin n_bad++; $display("FAIL nochan_reload got err %b addr %h exp 0 49000", rd_err, mem_addr); end
  endtask

  initial begin
    mcu_rst = 1'b1; mcu_end = 1'b1; rd_load = 1'b0; rd_req = 1'b0; rd_ch_sel = 5'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_large_wrap();
    test_ch25_sweep();
    test_err_no_end();
    test_bad_load();
    test_rst_in_read();
    test_rst_in_ack();
    test_err_no_channel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
